decoder38_scan: RTL and testbench

Registered 3-to-8 decoder that drives eight one-hot LEDs from a 3-bit index. It is the inverse of the board's 8-3 priority encoder. The index is loaded from switches on a debounced-button rising edge (manual mode) or stepped automatically by a prescaled scanner (scan mode). The block sits between board switches/buttons and the LED bank, and exposes the current index for a seven-segment display.

---
 rtl/decoder38_scan.sv | 110 +++++++++++
 tb/tb_decoder38_scan.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/decoder38_scan.sv
`default_nettype none
// ============================================================================
// Module   : decoder38_scan
// Brief    : Registered 3-to-8 one-hot LED decoder with manual load and
//            prescaled auto-scan of the index.
// Revision : 1.0 - initial release
// ============================================================================
module decoder38_scan #(
  parameter int SCAN_DIV = 5000000,
  parameter int DIV_W    = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode,
  input  logic       dir,
  input  logic [2:0] code,
  input  logic       load,
  output logic [7:0] y,
  output logic [2:0] idx,
  output logic       valid,
  output logic       wrap
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] C_LAST = DIV_W'(SCAN_DIV - 1);

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       y_q, y_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             s0_q, s0_d, s1_q, s1_d, p_q, p_d;
  logic             rise;

  always_comb begin
    state_d = IDLE;
    idx_d   = idx_q;
    cnt_d   = '0;
    wrap_d  = 1'b0;
    s0_d    = load;
    s1_d    = s0_q;
    p_d     = s1_q;
    rise    = s1_q & ~p_q;

    if (en) begin
      state_d = mode ? SCAN : MANUAL;
    end

    if (state_q == MANUAL && state_d == MANUAL && rise) begin
      idx_d = code;
    end

    // Counting only while staying in SCAN keeps the entry edge clearing the prescaler.
    if (state_q == SCAN && state_d == SCAN) begin
      if (cnt_q == C_LAST) begin
        cnt_d = '0;
        if (dir) begin
          idx_d  = idx_q - 3'd1;
          wrap_d = (idx_q == 3'd0);
        end else begin
          idx_d  = idx_q + 3'd1;
          wrap_d = (idx_q == 3'd7);
        end
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end

    valid_d = (state_d != IDLE);
    y_d     = valid_d ? (8'b1 << idx_d) : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      y_q     <= 8'h00;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      p_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      p_q     <= p_d;
    end
  end

  assign y     = y_q;
  assign idx   = idx_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder38_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder38_scan
// Brief    : Scoreboard bench for decoder38_scan with SCAN_DIV = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder38_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, mode = 1'b0, dir = 1'b0, load = 1'b0;
  logic [2:0] code = 3'd0;
  logic [7:0] y;
  logic [2:0] idx;
  logic       valid, wrap;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [7:0] y;
    logic [2:0] idx;
    logic       v;
    logic       w;
    string      name;
  } exp_t;

  exp_t sb[$];

  decoder38_scan #(.SCAN_DIV(4), .DIV_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dir(dir),
    .code(code), .load(load), .y(y), .idx(idx), .valid(valid), .wrap(wrap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] ey, input logic [2:0] ei,
                       input logic ev, input logic ew);
    checks++;
    if (y !== ey || idx !== ei || valid !== ev || wrap !== ew) begin
      failures++;
      $display("FAIL %s: got y=%h idx=%0d valid=%b wrap=%b, expected y=%h idx=%0d valid=%b wrap=%b",
               name, y, idx, valid, wrap, ey, ei, ev, ew);
    end
  endtask

  // Expectation for the state visible after 'after' more rising edges.
  task automatic expect_at(input int after, input logic [7:0] ey, input logic [2:0] ei,
                           input logic ev, input logic ew, input string name);
    exp_t e;
    e.cyc = cyc + after; e.y = ey; e.idx = ei; e.v = ev; e.w = ew; e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are continuously presented, so compare at the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", e.name, e.cyc, cyc);
      end else begin
        check(e.name, e.y, e.idx, e.v, e.w);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] up_idx [4];
    logic [7:0] up_y   [4];
    up_idx = '{3'd6, 3'd7, 3'd0, 3'd1};
    up_y   = '{8'h40, 8'h80, 8'h01, 8'h02};

    // Reset state
    tick(2);
    expect_at(0, 8'h00, 3'd0, 1'b0, 1'b0, "reset");
    tick(1);
    rst_n = 1'b1;
    expect_at(1, 8'h00, 3'd0, 1'b0, 1'b0, "idle_after_reset");
    tick(1);

    // Enable in manual mode
    en = 1'b1;
    mode = 1'b0;
    expect_at(1, 8'h01, 3'd0, 1'b1, 1'b0, "en_manual");
    tick(1);

    // Load code 5 with a 3-cycle press: lands two edges after first sample
    code = 3'd5;
    load = 1'b1;
    expect_at(1, 8'h01, 3'd0, 1'b1, 1'b0, "load_sync1");
    expect_at(2, 8'h01, 3'd0, 1'b1, 1'b0, "load_sync2");
    expect_at(3, 8'h20, 3'd5, 1'b1, 1'b0, "load5");
    expect_at(4, 8'h20, 3'd5, 1'b1, 1'b0, "load5_hold");
    tick(3);
    load = 1'b0;
    tick(1);
    code = 3'd2;
    expect_at(1, 8'h20, 3'd5, 1'b1, 1'b0, "no_press1");
    expect_at(4, 8'h20, 3'd5, 1'b1, 1'b0, "no_press4");
    tick(4);

    // Load 6 as the scan start point
    code = 3'd6;
    load = 1'b1;
    expect_at(3, 8'h40, 3'd6, 1'b1, 1'b0, "load6");
    tick(3);
    load = 1'b0;
    tick(3);

    // Scan up from 6: 6,7,0,1 each for 4 cycles, wrap on 7->0
    mode = 1'b1;
    dir = 1'b0;
    for (int k = 1; k <= 16; k++)
      expect_at(k, up_y[(k-1)/4], up_idx[(k-1)/4], 1'b1, (k == 9), "scan_up");
    tick(16);

    // Scan down from 1: 1 -> 0 next edge, 0 -> 7 four later with wrap; press ignored
    dir = 1'b1;
    code = 3'd3;
    load = 1'b1;
    for (int k = 1; k <= 4; k++) expect_at(k, 8'h01, 3'd0, 1'b1, 1'b0, "scan_dn_0");
    for (int k = 5; k <= 8; k++) expect_at(k, 8'h80, 3'd7, 1'b1, (k == 5), "scan_dn_7");
    tick(3);
    load = 1'b0;
    tick(5);

    // Continue down to 3
    expect_at(1,  8'h40, 3'd6, 1'b1, 1'b0, "scan_dn_6");
    expect_at(5,  8'h20, 3'd5, 1'b1, 1'b0, "scan_dn_5");
    expect_at(9,  8'h10, 3'd4, 1'b1, 1'b0, "scan_dn_4");
    expect_at(13, 8'h08, 3'd3, 1'b1, 1'b0, "scan_dn_3");
    tick(14);

    // Drop enable mid-scan: LEDs off, index retained
    en = 1'b0;
    expect_at(1, 8'h00, 3'd3, 1'b0, 1'b0, "idle_mid_scan");
    expect_at(2, 8'h00, 3'd3, 1'b0, 1'b0, "idle_hold");
    tick(2);
    en = 1'b1;
    mode = 1'b0;
    expect_at(1, 8'h08, 3'd3, 1'b1, 1'b0, "reenable");
    tick(1);

    // Resume scan: prescaler restarts, first step four cycles later
    mode = 1'b1;
    for (int k = 1; k <= 4; k++) expect_at(k, 8'h08, 3'd3, 1'b1, 1'b0, "resume_hold");
    expect_at(5, 8'h04, 3'd2, 1'b1, 1'b0, "resume_step");
    tick(5);
    @(negedge clk);
    #1;

    // Asynchronous reset between edges
    rst_n = 1'b0;
    #1;
    check("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    mode = 1'b0;
    tick(1);
    rst_n = 1'b1;
    expect_at(1, 8'h01, 3'd0, 1'b1, 1'b0, "after_reset_manual");
    tick(2);

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
